// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and elaboration helpers for pipe_shift_add_mul.
//   DEF_*          default widths / bits-per-stage
//   ceil_div       integer ceiling division
//   calc_stages    number of pipeline stages for a coefficient width
//   calc_prod_w    full-precision product width
//   group_bits     coefficient bits handled by stage k (last group may be short)
package mul_pkg;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_COEF_W         = 8;
    localparam int DEF_BITS_PER_STAGE = 2;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int calc_stages(input int coef_w, input int bps);
        return ceil_div(coef_w, bps);
    endfunction

    function automatic int calc_prod_w(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

    function automatic int group_bits(input int coef_w, input int bps, input int k);
        return ((k + 1) * bps > coef_w) ? (coef_w - k * bps) : bps;
    endfunction

endpackage

// File: rtl/mul_stage.sv
// mul_stage: one registered stage of the shift-add multiplier.
// Adds the partial products for coefficient bits [LO_BIT, LO_BIT+N_BITS-1]
// to the incoming accumulator and registers {v, a, b, acc} when i_adv is high.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_adv             pipeline advance enable (hold when low)
//   i_v/i_a/i_b/i_acc  previous stage (or input) valid, operands, accumulator
//   o_v/o_a/o_b/o_acc  registered stage outputs
module mul_stage
    import mul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int PROD_W = DEF_DATA_W + DEF_COEF_W,
    parameter int LO_BIT = 0,
    parameter int N_BITS = DEF_BITS_PER_STAGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_adv,
    input  logic              i_v,
    input  logic [DATA_W-1:0] i_a,
    input  logic [COEF_W-1:0] i_b,
    input  logic [PROD_W-1:0] i_acc,
    output logic              o_v,
    output logic [DATA_W-1:0] o_a,
    output logic [COEF_W-1:0] o_b,
    output logic [PROD_W-1:0] o_acc
);

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_part [0:N_BITS];

    logic              r_v;
    logic [DATA_W-1:0] r_a;
    logic [COEF_W-1:0] r_b;
    logic [PROD_W-1:0] r_acc;

    assign w_a_ext   = PROD_W'(i_a);
    assign w_part[0] = i_acc;

    // Adder chain over this stage's coefficient bits.
    for (genvar j = 0; j < N_BITS; j++) begin : g_pp
        assign w_part[j+1] = w_part[j] +
                             (i_b[LO_BIT + j] ? (w_a_ext << (LO_BIT + j)) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v   <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_adv) begin
            r_v   <= i_v;
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= w_part[N_BITS];
        end
    end

    assign o_v   = r_v;
    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/pipe_shift_add_mul.sv
// pipe_shift_add_mul: pipelined unsigned shift-add multiplier,
// out_data = in_a * in_b at full precision, valid/ready with global stall.
// Optional macro MUL_OUT_REG_EN adds a flop stage at the output (latency +1).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready = advance, forced 1 in reset)
//   in_a [DATA_W]         multiplicand
//   in_b [COEF_W]         multiplier
//   out_valid/out_ready   output handshake
//   out_data [PROD_W]     product
module pipe_shift_add_mul
    import mul_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int COEF_W         = DEF_COEF_W,
    parameter int BITS_PER_STAGE = DEF_BITS_PER_STAGE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [COEF_W-1:0]        in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+COEF_W-1:0] out_data
);

    localparam int STAGES = calc_stages(COEF_W, BITS_PER_STAGE);
    localparam int PROD_W = calc_prod_w(DATA_W, COEF_W);

    logic              w_adv;
    logic              w_v   [0:STAGES];
    logic [DATA_W-1:0] w_a   [0:STAGES];
    logic [COEF_W-1:0] w_b   [0:STAGES];
    logic [PROD_W-1:0] w_acc [0:STAGES];

    assign w_v[0]   = in_valid;
    assign w_a[0]   = in_a;
    assign w_b[0]   = in_b;
    assign w_acc[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mul_stage #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .PROD_W (PROD_W),
            .LO_BIT (k * BITS_PER_STAGE),
            .N_BITS (group_bits(COEF_W, BITS_PER_STAGE, k))
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_adv (w_adv),
            .i_v   (w_v[k]),
            .i_a   (w_a[k]),
            .i_b   (w_b[k]),
            .i_acc (w_acc[k]),
            .o_v   (w_v[k+1]),
            .o_a   (w_a[k+1]),
            .o_b   (w_b[k+1]),
            .o_acc (w_acc[k+1])
        );
    end

`ifdef MUL_OUT_REG_EN
    logic              r_out_v;
    logic [PROD_W-1:0] r_out_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_v    <= 1'b0;
            r_out_data <= '0;
        end else if (w_adv) begin
            r_out_v    <= w_v[STAGES];
            r_out_data <= w_acc[STAGES];
        end
    end

    assign out_valid = r_out_v;
    assign out_data  = r_out_data;
`else
    assign out_valid = w_v[STAGES];
    assign out_data  = w_acc[STAGES];
`endif

    // Only a valid, unaccepted output stalls; bubbles always advance.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv | ~rst_n;

endmodule

// File: tb/tb_pipe_shift_add_mul.sv
// Scoreboard bench: drivers push a*b on each accepted input, negedge monitors
// pop and compare on each output transfer. Two DUTs: default (BPS=2) and BPS=3.
module tb_pipe_shift_add_mul;

`ifdef MUL_OUT_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT1 = 4 + EXTRA;
    localparam int LAT2 = 3 + EXTRA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, r1, ov1, ordy1 = 1'b1;
    logic [7:0]  a1 = '0, b1 = '0;
    logic [15:0] d1;
    logic        v2 = 1'b0, r2, ov2, ordy2 = 1'b1;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [15:0] d2;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [15:0] q1[$];
    logic [15:0] q2[$];
    bit measure1 = 0, pend1 = 0, measure2 = 0, pend2 = 0;
    int acc_cyc1, acc_cyc2;
    bit stall1 = 0, stall2 = 0;
    logic [15:0] prev_d1, prev_d2;

    pipe_shift_add_mul #(.DATA_W(8), .COEF_W(8), .BITS_PER_STAGE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(d1));

    pipe_shift_add_mul #(.DATA_W(8), .COEF_W(8), .BITS_PER_STAGE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(d2));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, DUT 1
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            pend1  = 0;
            stall1 = 0;
        end else begin
            if (stall1) begin
                check("dut1_hold_valid", ov1, 1);
                check("dut1_hold_data", d1, prev_d1);
            end
            if (ov1 && !ordy1) check("dut1_stall_in_ready", r1, 0);
            if (pend1 && ov1) begin
                check("dut1_latency", cyc - acc_cyc1, LAT1);
                pend1 = 0;
            end
            if (ov1 && ordy1) begin
                check("dut1_out_expected", q1.size() > 0, 1);
                if (q1.size() > 0) check("dut1_data", d1, q1.pop_front());
            end
            if (v1 && r1) begin
                q1.push_back(16'(a1) * 16'(b1));
                if (measure1) begin acc_cyc1 = cyc; pend1 = 1; measure1 = 0; end
            end
            stall1  = ov1 && !ordy1;
            prev_d1 = d1;
        end
    end

    // Monitor / scoreboard, DUT 2
    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
            pend2  = 0;
            stall2 = 0;
        end else begin
            if (stall2) begin
                check("dut2_hold_valid", ov2, 1);
                check("dut2_hold_data", d2, prev_d2);
            end
            if (pend2 && ov2) begin
                check("dut2_latency", cyc - acc_cyc2, LAT2);
                pend2 = 0;
            end
            if (ov2 && ordy2) begin
                check("dut2_out_expected", q2.size() > 0, 1);
                if (q2.size() > 0) check("dut2_data", d2, q2.pop_front());
            end
            if (v2 && r2) begin
                q2.push_back(16'(a2) * 16'(b2));
                if (measure2) begin acc_cyc2 = cyc; pend2 = 1; measure2 = 0; end
            end
            stall2  = ov2 && !ordy2;
            prev_d2 = d2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b);
        bit acc = 0;
        int guard = 0;
        v1 = 1'b1; a1 = a; b1 = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = r1;
            step();
            guard++;
        end
        check("dut1_send_accepted", acc, 1);
        v1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b);
        bit acc = 0;
        int guard = 0;
        v2 = 1'b1; a2 = a; b2 = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = r2;
            step();
            guard++;
        end
        check("dut2_send_accepted", acc, 1);
        v2 = 1'b0;
    endtask

    task automatic drain1();
        int guard = 0;
        while ((q1.size() != 0 || ov1) && guard < 300) begin step(); guard++; end
        repeat (LAT1 + 2) step();
        check("dut1_drained", q1.size(), 0);
    endtask

    task automatic drain2();
        int guard = 0;
        while ((q2.size() != 0 || ov2) && guard < 300) begin step(); guard++; end
        repeat (LAT2 + 2) step();
        check("dut2_drained", q2.size(), 0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("reset_in_ready", r1, 1);
            step();
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", ov1, 0);
        check("reset_out_data", d1, 0);
        check("reset_out_valid2", ov2, 0);
        step();
    endtask

    bit done;

    initial begin
        step();
        do_reset(2);

        // Sweep 0..15 x 15, back to back
        measure1 = 1;
        for (int i = 0; i < 16; i++) send1(8'(i), 8'd15);
        drain1();

        // Max values and zero coefficient
        send1(8'd255, 8'd255);
        send1(8'd255, 8'd0);
        send1(8'd0, 8'd77);
        drain1();

        // Backpressure: 8 items, hold out_ready low 5 cycles at first out_valid
        fork
            begin
                for (int i = 0; i < 8; i++) send1(8'(10 + i * 7), 8'(3 + i * 29));
            end
            begin
                int g = 0;
                while (!ov1 && g < 100) begin @(negedge clk); g++; end
                step();
                ordy1 = 1'b0;
                repeat (5) step();
                ordy1 = 1'b1;
            end
        join
        drain1();

        // Reset with 3 items in flight; input during reset must be dropped
        send1(8'd11, 8'd12);
        send1(8'd13, 8'd14);
        send1(8'd15, 8'd16);
        v1 = 1'b1; a1 = 8'd99; b1 = 8'd99;
        rst_n = 1'b0;
        step();
        v1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", ov1, 0);
        step();
        measure1 = 1;
        send1(8'd7, 8'd9);
        drain1();

        // Random traffic with random backpressure on DUT 1
        done = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send1(8'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) step();
                end
                done = 1;
            end
            begin
                while (!done) begin step(); ordy1 = ($urandom_range(0, 2) != 0); end
                ordy1 = 1'b1;
            end
        join
        drain1();

        // DUT 2 (BITS_PER_STAGE=3): latency then 200 random pairs
        measure2 = 1;
        send2(8'd7, 8'd9);
        drain2();
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send2(8'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) step();
                end
                done = 1;
            end
            begin
                while (!done) begin step(); ordy2 = ($urandom_range(0, 3) != 0); end
                ordy2 = 1'b1;
            end
        join
        drain2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        n_fails++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
